// File: rtl/ldunit.sv
// rtl/ldunit.sv - multi-cycle load unit: word-aligned reads, byte merge, sign/zero extension
module ldunit (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] addr,
   input  logic [31:0] ir,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   input  logic        mem_ack,
   input  logic [31:0] mem_rdata,
   output logic [31:0] out,
   output logic        done,
   output logic        busy,
   output logic        err
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ0 = 2'd1,
      REQ1 = 2'd2,
      FIN  = 2'd3
   } state_t;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   state_t      state;
   state_t      state_nx;
   logic [2:0]  f3;
   logic [1:0]  off;
   logic [29:0] base_w;
   logic [31:0] w0;
   logic        accept;
   logic        start_legal;

   function automatic logic is_legal(input logic [2:0] f);
      case (f)
         F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: is_legal = 1'b1;
         default:                             is_legal = 1'b0;
      endcase
   endfunction

   // Halfwords straddle only from offset 3; words straddle from any non-zero offset.
   function automatic logic spans(input logic [2:0] f, input logic [1:0] o);
      spans = ((f == F3_LH || f == F3_LHU) && o == 2'd3) ||
              (f == F3_LW && o != 2'd0);
   endfunction

   // Shift the two-word window down by the byte offset, then size and extend.
   function automatic logic [31:0] extract(input logic [2:0] f, input logic [1:0] o,
                                           input logic [31:0] hi, input logic [31:0] lo);
      logic [63:0] sh;
      sh = {hi, lo} >> {o, 3'b000};
      case (f)
         F3_LB:   extract = {{24{sh[7]}}, sh[7:0]};
         F3_LH:   extract = {{16{sh[15]}}, sh[15:0]};
         F3_LBU:  extract = {24'h0, sh[7:0]};
         F3_LHU:  extract = {16'h0, sh[15:0]};
         default: extract = sh[31:0];
      endcase
   endfunction

   // A new load may be taken in IDLE or in the FIN cycle of the previous one.
   assign accept      = start && (state == IDLE || state == FIN);
   assign start_legal = is_legal(ir[14:12]);

   // State register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state and handshake outputs; memory bus is quiet outside REQ0/REQ1.
   always_comb begin
      state_nx = state;
      mem_rd   = 1'b0;
      mem_addr = 32'h0;
      done     = 1'b0;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = start_legal ? REQ0 : FIN;
            end
         end
         REQ0: begin
            mem_rd   = 1'b1;
            busy     = 1'b1;
            mem_addr = {base_w, 2'b00};
            if (mem_ack) begin
               state_nx = spans(f3, off) ? REQ1 : FIN;
            end
         end
         REQ1: begin
            mem_rd   = 1'b1;
            busy     = 1'b1;
            mem_addr = {base_w + 30'd1, 2'b00};
            if (mem_ack) begin
               state_nx = FIN;
            end
         end
         FIN: begin
            done = 1'b1;
            if (start) begin
               state_nx = start_legal ? REQ0 : FIN;
            end else begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Capture the request, the first word, and the final result on entry to FIN.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         f3     <= 3'b000;
         off    <= 2'b00;
         base_w <= 30'h0;
         w0     <= 32'h0;
         out    <= 32'h0;
         err    <= 1'b0;
      end else begin
         if (accept) begin
            f3     <= ir[14:12];
            off    <= addr[1:0];
            base_w <= addr[31:2];
            if (!start_legal) begin
               out <= 32'h0;
               err <= 1'b1;
            end
         end
         if (state == REQ0 && mem_ack) begin
            w0 <= mem_rdata;
            if (!spans(f3, off)) begin
               out <= extract(f3, off, 32'h0, mem_rdata);
               err <= 1'b0;
            end
         end
         if (state == REQ1 && mem_ack) begin
            out <= extract(f3, off, mem_rdata, w0);
            err <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_ldunit.sv
// tb/tb_ldunit.sv - scoreboard bench for ldunit
module tb_ldunit;

   logic        clock;
   logic        reset;
   logic        start;
   logic [31:0] addr;
   logic [31:0] ir;
   logic [31:0] mem_addr;
   logic        mem_rd;
   logic        mem_ack;
   logic [31:0] mem_rdata;
   logic [31:0] out;
   logic        done;
   logic        busy;
   logic        err;

   ldunit dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .addr      (addr),
      .ir        (ir),
      .mem_addr  (mem_addr),
      .mem_rd    (mem_rd),
      .mem_ack   (mem_ack),
      .mem_rdata (mem_rdata),
      .out       (out),
      .done      (done),
      .busy      (busy),
      .err       (err)
   );

   typedef struct {
      logic [31:0] exp_out;
      logic        exp_err;
      int          lat;
      int          start_cyc;
   } sb_entry_t;

   sb_entry_t   sb_q[$];
   logic [31:0] rd_q[$];
   int          checks;
   int          errors;
   int          cyc;
   int          wait_cycles;
   int          wait_cnt;
   logic [31:0] wait_addr;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [31:0] a);
      case (a)
         32'h0000_0100: mem_read = 32'h80FF7F01;
         32'h0000_0104: mem_read = 32'hCAFEBABE;
         32'hFFFF_FFFC: mem_read = 32'h11223344;
         32'h0000_0000: mem_read = 32'h55667788;
         default:       mem_read = 32'h0;
      endcase
   endfunction

   // Memory responder: acks after wait_cycles, checks read order and stability while waiting.
   always @(negedge clock) begin
      if (reset || !mem_rd) begin
         mem_ack  = 1'b0;
         wait_cnt = 0;
      end else if (wait_cnt < wait_cycles) begin
         if (wait_cnt > 0) check("addr_stable", mem_addr, wait_addr);
         wait_addr = mem_addr;
         mem_ack   = 1'b0;
         wait_cnt++;
      end else begin
         if (wait_cnt > 0) check("addr_stable", mem_addr, wait_addr);
         if (rd_q.size() == 0) begin
            check("unexpected_read", mem_addr, 32'hDEAD_BEEF);
         end else begin
            check("read_addr", mem_addr, rd_q.pop_front());
         end
         mem_rdata = mem_read(mem_addr);
         mem_ack   = 1'b1;
         wait_cnt  = 0;
      end
   end

   // Result monitor: pops the scoreboard on every done pulse.
   always @(negedge clock) begin
      if (!reset && done) begin
         if (sb_q.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            sb_entry_t e;
            e = sb_q.pop_front();
            check("out", out, e.exp_out);
            check("err", {31'h0, err}, {31'h0, e.exp_err});
            check("latency", cyc - e.start_cyc, e.lat);
         end
      end
   end

   // Drive a start pulse at a negedge; caller has already queued the expected reads.
   task automatic issue(input logic [31:0] a, input logic [2:0] f, input logic [31:0] eo,
                        input logic ee, input int lat);
      sb_entry_t e;
      e.exp_out   = eo;
      e.exp_err   = ee;
      e.lat       = lat;
      e.start_cyc = cyc;
      sb_q.push_back(e);
      addr  = a;
      ir    = 32'h0000_0003 | ({29'h0, f} << 12);
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   task automatic drain();
      for (int n = 0; n < 60 && sb_q.size() > 0; n++) @(negedge clock);
      if (sb_q.size() > 0) begin
         check("drain_timeout", sb_q.size(), 0);
         sb_q.delete();
      end
      @(negedge clock);
      @(negedge clock);
   endtask

   initial begin
      checks      = 0;
      errors      = 0;
      cyc         = 0;
      wait_cycles = 0;
      wait_cnt    = 0;
      wait_addr   = 32'h0;
      reset       = 1'b1;
      start       = 1'b0;
      addr        = 32'h0;
      ir          = 32'h0;
      mem_ack     = 1'b0;
      mem_rdata   = 32'h0;
      repeat (3) @(negedge clock);
      check("rst_mem_addr", mem_addr, 32'h0);
      check("rst_mem_rd", {31'h0, mem_rd}, 32'h0);
      check("rst_out", out, 32'h0);
      check("rst_done", {31'h0, done}, 32'h0);
      check("rst_busy", {31'h0, busy}, 32'h0);
      check("rst_err", {31'h0, err}, 32'h0);
      reset = 1'b0;
      @(negedge clock);

      // Byte loads
      rd_q.push_back(32'h100); issue(32'h101, 3'b000, 32'h0000007F, 1'b0, 2); drain();
      rd_q.push_back(32'h100); issue(32'h103, 3'b000, 32'hFFFFFF80, 1'b0, 2); drain();
      rd_q.push_back(32'h100); issue(32'h102, 3'b100, 32'h000000FF, 1'b0, 2); drain();

      // Halfword loads, including one straddling the word boundary
      rd_q.push_back(32'h100); issue(32'h102, 3'b001, 32'hFFFF80FF, 1'b0, 2); drain();
      rd_q.push_back(32'h100); issue(32'h102, 3'b101, 32'h000080FF, 1'b0, 2); drain();
      rd_q.push_back(32'h100); rd_q.push_back(32'h104);
      issue(32'h103, 3'b001, 32'hFFFFBE80, 1'b0, 3); drain();

      // Spanning word and address wrap
      rd_q.push_back(32'h100); rd_q.push_back(32'h104);
      issue(32'h101, 3'b010, 32'hBE80FF7F, 1'b0, 3); drain();
      rd_q.push_back(32'hFFFFFFFC); rd_q.push_back(32'h0);
      issue(32'hFFFFFFFE, 3'b010, 32'h77881122, 1'b0, 3); drain();

      // Wait states, with a start pulse while busy that must be ignored
      wait_cycles = 3;
      rd_q.push_back(32'h100);
      issue(32'h100, 3'b010, 32'h80FF7F01, 1'b0, 5);
      addr  = 32'h104;
      ir    = 32'h0000_0003;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      drain();
      wait_cycles = 0;

      // Back-to-back: second start lands in the FIN cycle of the first
      rd_q.push_back(32'h100);
      issue(32'h101, 3'b000, 32'h0000007F, 1'b0, 2);
      for (int n = 0; n < 20 && !done; n++) @(negedge clock);
      if (!done) check("b2b_done_timeout", 32'd0, 32'd1);
      rd_q.push_back(32'h100); rd_q.push_back(32'h104);
      issue(32'h101, 3'b010, 32'hBE80FF7F, 1'b0, 3);
      drain();

      // Illegal funct3, then a legal load clears err
      issue(32'h100, 3'b011, 32'h0, 1'b1, 1); drain();
      issue(32'h100, 3'b111, 32'h0, 1'b1, 1); drain();
      rd_q.push_back(32'h100); issue(32'h102, 3'b100, 32'h000000FF, 1'b0, 2); drain();

      // Asynchronous reset during REQ1 aborts the load
      wait_cycles = 2;
      rd_q.push_back(32'h100); rd_q.push_back(32'h104);
      issue(32'h101, 3'b010, 32'hBE80FF7F, 1'b0, 3);
      for (int n = 0; n < 20 && !(mem_rd && mem_addr == 32'h104); n++) @(negedge clock);
      check("abort_in_req1", mem_addr, 32'h104);
      reset = 1'b1;
      #1;
      check("abort_mem_rd", {31'h0, mem_rd}, 32'h0);
      check("abort_busy", {31'h0, busy}, 32'h0);
      check("abort_mem_addr", mem_addr, 32'h0);
      check("abort_out", out, 32'h0);
      check("abort_err", {31'h0, err}, 32'h0);
      sb_q.delete();
      rd_q.delete();
      wait_cycles = 0;
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (6) @(negedge clock);
      check("abort_done", {31'h0, done}, 32'h0);

      // One more load after the abort to confirm recovery
      rd_q.push_back(32'h100); issue(32'h103, 3'b000, 32'hFFFFFF80, 1'b0, 2); drain();
      check("rd_q_empty", rd_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
